seq_detect_ctrl: RTL
====================

# seq_detect_ctrl

Programmable serial-pattern detection controller for the bit-serial input path. It holds the pattern configuration and sequences a detection window over qualified input bits. It supports overlapping and non-overlapping matching, counts matches and halts with a sticky interrupt when a programmed threshold is reached. Software-facing control (`cfg_*`, `start`, `stop`, `clr`) sits on one side and the raw `din` stream on the other.

## Interface
**Parameters**
- `MAX_LEN`, default 8: maximum pattern length in bits (≥2).
- `CNT_W`, default 8: width of the match counter and threshold.

**Ports**
- `clk`, input, 1: clock. All logic is rising-edge.
- `reset`, input, 1: asynchronous, active-high.
- `cfg_wr`, input, 1: load `cfg_*` fields. Accepted only in IDLE; ignored in other states.
- `cfg_pattern`, input, MAX_LEN: pattern. `cfg_pattern[len-1]` is the first bit expected; `cfg_pattern[0]` is the last.
- `cfg_len`, input, $clog2(MAX_LEN+1): pattern length. 0 means never match. Values above MAX_LEN clamp to MAX_LEN.
- `cfg_overlap`, input, 1: 1 selects overlapping detection; 0 selects non-overlapping.
- `cfg_threshold`, input, CNT_W: match count that triggers HALT. 0 disables the threshold.
- `start`, input, 1: pulse. IDLE→ARMED, or HALT→ARMED.
- `stop`, input, 1: pulse. Any state→IDLE.
- `clr`, input, 1: pulse. Clears window, fill, `match_count` and `irq`.
- `din_valid`, input, 1: qualifies `din`.
- `din`, input, 1: serial data bit.
- `irq_ack`, input, 1: clears `irq`.
- `busy`, output, 1: 1 in ARMED.
- `match`, output, 1: registered one-cycle pulse per detection.
- `match_count`, output, CNT_W: saturating count of matches.
- `irq`, output, 1: sticky, set on threshold reach.

## Operation
- **Control FSM states:** IDLE, ARMED, HALT. Reset state is IDLE.
- **IDLE:**
  - `din` is ignored.
  - `cfg_wr` loads the pattern, length, overlap and threshold registers.
  - `start` → ARMED and clears window and fill. `match_count` is retained.
- **ARMED:** each cycle with `din_valid=1`:
  - Shift the window: `win_next = {win[MAX_LEN-2:0], din}`.
  - `fill_next = min(fill+1, MAX_LEN)`.
  - Hit when `len≠0`, `fill_next ≥ len` and `win_next[len-1:0] == pattern[len-1:0]`.
- **On hit:**
  - `match` is pulsed.
  - `match_count` increments, saturating at 2^CNT_W−1.
  - Overlapping mode keeps fill. Non-overlapping mode sets fill to 0, so the next match needs `len` fresh bits.
- **Threshold:** if `threshold≠0` and the post-increment count equals `threshold`, set `irq` and go to HALT the same edge.
- **HALT:** `din` is ignored and the count is frozen.
  - `start` → ARMED; window and fill are cleared, the count is kept, and the threshold will not re-fire until the count wraps via `clr`.
  - `stop` → IDLE.
- **`clr`:**
  - Clears window, fill, `match_count`, `irq` and the pending `match` in any state.
  - HALT→IDLE. Other states are unchanged.
- **Priority on the same cycle:** `stop` > `clr` > `start` > data.
  - `start` in ARMED is ignored.
  - If `irq` set and `irq_ack` occur together, set wins.
- **Reset values:**
  - State IDLE.
  - `busy=0`, `match=0`, `match_count=0`, `irq=0`.
  - Window and fill 0.
  - Pattern `…01010` (pattern[3:0]=4'b1010), `len=4`, `overlap=1`, `threshold=0`.

## Timing
- Detection latency is 1 cycle. `match` is high in the cycle after the edge that samples the final pattern bit, for exactly one cycle. It is Moore-style, driven from a register.
- `match_count` and `irq` update on the same edge that raises `match`.
- `busy` deasserts on the edge of the threshold hit.
- `cfg_wr` takes effect on the next edge.
- `start` with `din_valid` in the same IDLE cycle: the bit is not sampled. The first sampled bit is the one in the cycle after `start`.
- Gaps in `din_valid` do not reset the window.
- Reset mid-stream: all outputs go to reset values immediately (asynchronous). The configuration returns to the defaults.

## Test plan
1. Defaults after reset, `start`, then `din`=1,0,1,0,1,0,1,0 with `din_valid=1` every cycle → `match` pulses after bits 4, 6 and 8; `match_count`=3; `irq`=0.
2. `cfg_wr` with pattern 4'b1010, `len=4`, `overlap=0`, then `start`, then the same 8-bit stream → matches after bits 4 and 8 only; `match_count`=2.
3. Pattern 3'b111, `len=3`, `overlap=1`, `threshold=2`; stream 1,1,1,1,1 → matches after bits 3 and 4; `irq`=1 and HALT after bit 4; bit 5 is ignored; `busy`=0; `match_count`=2.
4. From HALT: assert `irq_ack` in the same cycle as a threshold hit → `irq` stays 1. Then `irq_ack` alone → `irq`=0. Then `clr` → state IDLE and `match_count`=0.
5. `stop` and `start` together in IDLE → stays IDLE, `busy`=0. `cfg_wr` while ARMED → pattern unchanged, verified by the next default 1010 match. `cfg_len=0` → no match on any stream.
6. Assert `reset` mid-pattern after 1,0,1, then deassert and `start`, then feed 0 → no match. Reset values are verified on all outputs.

Source files
------------

// File: rtl/seq_detect_ctrl.sv
// Serial pattern detector. Holds the pattern configuration, runs a sliding
// window over qualified input bits, counts matches and halts on a threshold.
module seq_detect_ctrl #(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_wr,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_threshold,
  input  logic               start,
  input  logic               stop,
  input  logic               clr,
  input  logic               din_valid,
  input  logic               din,
  input  logic               irq_ack,
  output logic               busy,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               irq
);

  typedef enum logic [1:0] {IDLE, ARMED, HALT} state_t;

  localparam logic [MAX_LEN-1:0] PAT_RST = MAX_LEN'(4'b1010);
  localparam logic [LW-1:0]      LEN_RST = LW'((MAX_LEN < 4) ? MAX_LEN : 4);
  localparam logic [LW-1:0]      LEN_MAX = LW'(MAX_LEN);

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LW-1:0]      len_q, len_d;
  logic               overlap_q, overlap_d;
  logic [CNT_W-1:0]   thr_q, thr_d;
  logic [MAX_LEN-1:0] win_q, win_d;
  logic [LW-1:0]      fill_q, fill_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               irq_q, irq_d;

  logic [MAX_LEN-1:0] win_nx;
  logic [LW-1:0]      fill_nx;
  logic [CNT_W-1:0]   cnt_inc;
  logic               hit;

  always_comb begin
    win_nx  = {win_q[MAX_LEN-2:0], din};
    fill_nx = (fill_q == LEN_MAX) ? fill_q : fill_q + 1'b1;
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    hit     = (len_q != '0) && (fill_nx >= len_q);
    for (int i = 0; i < MAX_LEN; i++)
      if (i < int'(len_q) && win_nx[i] != pattern_q[i]) hit = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    thr_d     = thr_q;
    win_d     = win_q;
    fill_d    = fill_q;
    match_d   = 1'b0;
    cnt_d     = cnt_q;
    irq_d     = irq_q & ~irq_ack;

    if (cfg_wr && state_q == IDLE) begin
      pattern_d = cfg_pattern;
      len_d     = (int'(cfg_len) > MAX_LEN) ? LEN_MAX : cfg_len;
      overlap_d = cfg_overlap;
      thr_d     = cfg_threshold;
    end

    if (stop) begin
      state_d = IDLE;
    end else if (clr) begin
      win_d  = '0;
      fill_d = '0;
      cnt_d  = '0;
      irq_d  = 1'b0;
      if (state_q == HALT) state_d = IDLE;
    end else if (start && state_q != ARMED) begin
      state_d = ARMED;
      win_d   = '0;
      fill_d  = '0;
    end else if (state_q == ARMED && din_valid) begin
      win_d  = win_nx;
      fill_d = fill_nx;
      if (hit) begin
        match_d = 1'b1;
        cnt_d   = cnt_inc;
        if (!overlap_q) fill_d = '0;
        // Fire only when the count actually steps onto the threshold, so a
        // restart from HALT (or a saturated counter) never re-triggers.
        if (thr_q != '0 && cnt_inc == thr_q && cnt_q != thr_q) begin
          irq_d   = 1'b1;
          state_d = HALT;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pattern_q <= PAT_RST;
      len_q     <= LEN_RST;
      overlap_q <= 1'b1;
      thr_q     <= '0;
      win_q     <= '0;
      fill_q    <= '0;
      match_q   <= 1'b0;
      cnt_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      thr_q     <= thr_d;
      win_q     <= win_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      cnt_q     <= cnt_d;
      irq_q     <= irq_d;
    end
  end

  assign busy        = (state_q == ARMED);
  assign match       = match_q;
  assign match_count = cnt_q;
  assign irq         = irq_q;

endmodule
